floppy_sd_arbiter: RTL and testbench
====================================

# floppy_sd_arbiter

Shares the single host SD block port (`sd_lba`/`sd_rd`/`sd_wr`/`sd_ack`/`sd_buff_*`) among N floppy track units: 3.5" and 5.25" drives, each with its own track buffer. It arbitrates round-robin. A requester that asserts `req_lock` keeps the port for a whole track transfer, so multi-sector loads and saves are never interleaved. The block sits between the drive track units and the HPS/SD bridge in the IWM/floppy subsystem.

## Interface
Parameters:
- `N`, 4: number of requesters (2..8).
- `TIMEOUT`, 4096: idle cycles in HOLD before a lock is forcibly released.

Ports (`GW` = `$clog2(N)`):
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `req_rd`  in  N  per-requester read request; level, held until its `req_ack` rises.
- `req_wr`  in  N  per-requester write request; same rules as `req_rd`.
- `req_lba`  in  N*32  per-requester LBA; slice i = bits [32i+31:32i].
- `req_lock`  in  N  requester's `busy`; holds the grant between sectors.
- `req_buff_din`  in  N*8  per-requester buffer read data destined for SD.
- `req_ack`  out  N  `sd_ack` routed to the granted requester only.
- `sd_lba`  out  32  registered LBA to host.
- `sd_rd`  out  1  registered read strobe.
- `sd_wr`  out  1  registered write strobe.
- `sd_ack`  in  1  host acknowledge; high for the whole sector transfer.
- `sd_buff_din`  out  8  `req_buff_din` slice of the granted requester; 0 when nothing is granted.
- `grant_valid`  out  1  high in XFER and HOLD.
- `grant_id`  out  GW  index of the current or last grant.

`sd_buff_addr`, `sd_buff_dout` and `sd_buff_wr` are broadcast outside this block. Requesters qualify writes with their own `req_ack`.

## Operation
States: WAITACK, IDLE, XFER, HOLD.
- **WAITACK** (entered on reset)
  - Stay while `sd_ack`=1, then go to IDLE.
  - Guards against an ack left over from a transfer interrupted by reset.
- **IDLE**
  - Pending set P = `req_rd | req_wr`.
  - If P≠0, pick the first set bit searching upward from `rr_ptr` with wrap.
  - Latch `sel`, `sd_lba`=lba[sel], `sd_wr`=wr[sel] and `sd_rd`=rd[sel] & ~wr[sel]; write wins when both are set.
  - Go to XFER.
- **XFER**
  - While `sd_ack`=0, keep driving the strobes.
  - On the first cycle with `sd_ack`=1, clear `sd_rd`/`sd_wr`.
  - On the `sd_ack` falling edge (`old_ack`=1 and `sd_ack`=0):
    - `req_lock[sel]`=1: go to HOLD and clear the timer.
    - Otherwise: go to IDLE with `rr_ptr`=(sel+1) mod N.
- **HOLD**
  - `req_rd[sel]|req_wr[sel]`: latch lba and strobes as in IDLE, go to XFER, clear the timer.
  - Else if `req_lock[sel]`=0: go to IDLE with `rr_ptr`=sel+1 mod N.
  - Else if timer=TIMEOUT-1: go to IDLE with `rr_ptr`=sel+1 mod N (forced release).
  - Else increment the timer.
  - Other requesters are ignored while in HOLD.
- **Routing**
  - `req_ack[i]` = `sd_ack` & `grant_valid` & (sel==i).
  - In IDLE and WAITACK, `req_ack` is all zeros even if `sd_ack` is high.

Arithmetic:
- The timer is `$clog2(TIMEOUT)` bits wide and saturates at TIMEOUT-1.
- `rr_ptr` wraps modulo N; for non-power-of-2 N it wraps explicitly from N-1 to 0.
- LBA passes through unchanged.

## Timing
- Reset values: `sd_rd`=0, `sd_wr`=0, `sd_lba`=0, `req_ack`=0, `grant_valid`=0, `grant_id`=0, `sd_buff_din`=0, `rr_ptr`=0, state WAITACK.
- Request seen at edge k in IDLE: `sd_rd`/`sd_wr`/`sd_lba` are valid after edge k, one cycle of latency.
- `req_ack` and `sd_buff_din` are combinational from `sd_ack` and `sel`: zero added latency, as the DMA path requires.
- Strobes drop at the edge after `sd_ack` rises.
- Next-sector request in HOLD at edge k: strobes are re-asserted after edge k.
- Requests asserted simultaneously: lowest index at or above `rr_ptr` wins; the others wait with no loss.
- A request that drops before service is simply skipped; there is no sticky state.
- Reset mid-XFER: outputs go to 0 immediately, then the block waits in WAITACK for the host ack to drop.

## Structure
- Package `floppy_sd_pkg`:
  - `typedef enum logic [1:0] {WAITACK, IDLE, XFER, HOLD} fsd_state_t`.
  - Constant `FSD_LBA_W` = 32.
- Sub-module `floppy_sd_rr_pick`:
  - Combinational rotate-priority encoder.
  - Inputs: `req[N]`, `ptr[GW]`.
  - Outputs: `valid`, `idx[GW]`.
  - Reusable by other SD-port sharers.

## Test plan
- **Single read:** `req_rd[2]`=1, lba=0x640.
  - Expected: `sd_rd`=1 and `sd_lba`=0x640 one cycle later; `req_ack[2]` mirrors `sd_ack`; `req_ack[0,1,3]`=0.
- **Simultaneous requests, round-robin:** `rr_ptr`=0, rd on 1 and 3, no lock.
  - Expected: grant 1, then grant 3, then `rr_ptr`=0.
- **Locked 20-sector burst:** requester 0 locked; requester 1 requesting throughout.
  - Expected: 20 consecutive XFERs for requester 0 and none for requester 1 until `req_lock[0]` drops; then requester 1 is granted.
- **Lock timeout:** TIMEOUT=16, requester 2 locked and idle.
  - Expected: forced release at cycle 16 of HOLD, `grant_valid`=0, and requester 3's pending request is granted next.
- **rd+wr together:** both set on requester 1.
  - Expected: `sd_wr`=1, `sd_rd`=0.
- **Reset mid-transfer:** assert reset with `sd_ack`=1.
  - Expected: all outputs 0; no grant while `sd_ack` stays high; a new request is serviced only after `sd_ack` falls.

Source files
------------

// File: rtl/floppy_sd_pkg.sv
// rtl/floppy_sd_pkg.sv - shared types and constants for the floppy SD port arbiter
package floppy_sd_pkg;

    localparam int FSD_LBA_W = 32;

    typedef enum logic [1:0] {WAITACK, IDLE, XFER, HOLD} fsd_state_t;

endpackage

// File: rtl/floppy_sd_rr_pick.sv
// rtl/floppy_sd_rr_pick.sv - rotate-priority encoder: first set req bit at or above ptr, with wrap
module floppy_sd_rr_pick #(
    parameter int N  = 4,
    parameter int GW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] ptr,
    output logic          valid,
    output logic [GW-1:0] idx
);

    logic [GW:0] cand;

    // Scan from the farthest offset down so the nearest candidate is the last one written.
    always_comb begin
        valid = |req;
        idx   = '0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (GW + 1)'(k);
            if (cand >= (GW + 1)'(N)) begin
                cand = cand - (GW + 1)'(N);
            end
            if (req[cand[GW-1:0]]) begin
                idx = cand[GW-1:0];
            end
        end
    end

endmodule

// File: rtl/floppy_sd_arbiter.sv
// rtl/floppy_sd_arbiter.sv - round-robin sharer of the host SD block port among floppy track units
module floppy_sd_arbiter
    import floppy_sd_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 4096,
    parameter int GW      = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N-1:0]           req_rd,
    input  logic [N-1:0]           req_wr,
    input  logic [N*FSD_LBA_W-1:0] req_lba,
    input  logic [N-1:0]           req_lock,
    input  logic [N*8-1:0]         req_buff_din,
    output logic [N-1:0]           req_ack,
    output logic [FSD_LBA_W-1:0]   sd_lba,
    output logic                   sd_rd,
    output logic                   sd_wr,
    input  logic                   sd_ack,
    output logic [7:0]             sd_buff_din,
    output logic                   grant_valid,
    output logic [GW-1:0]          grant_id
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] LAST = GW'(N - 1);

    fsd_state_t            state, state_n;
    logic [GW-1:0]         sel, sel_n, rr_ptr, rr_ptr_n, load_idx, next_ptr;
    logic [TW-1:0]         timer, timer_n;
    logic [FSD_LBA_W-1:0]  lba_n;
    logic                  rd_n, wr_n, old_ack, do_load;
    logic                  pick_valid;
    logic [GW-1:0]         pick_idx;
    logic [FSD_LBA_W-1:0]  lba_a [N];
    logic [7:0]            din_a [N];

    for (genvar i = 0; i < N; i++) begin : g_slice
        assign lba_a[i]   = req_lba[FSD_LBA_W*i +: FSD_LBA_W];
        assign din_a[i]   = req_buff_din[8*i +: 8];
        assign req_ack[i] = sd_ack & grant_valid & (sel == GW'(i));
    end

    floppy_sd_rr_pick #(.N(N), .GW(GW)) u_pick (
        .req   (req_rd | req_wr),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign grant_valid = (state == XFER) || (state == HOLD);
    assign grant_id    = sel;
    assign sd_buff_din = grant_valid ? din_a[sel] : 8'h00;
    assign next_ptr    = (sel == LAST) ? '0 : sel + 1'b1;

    always_comb begin
        state_n  = state;
        sel_n    = sel;
        rr_ptr_n = rr_ptr;
        timer_n  = timer;
        lba_n    = sd_lba;
        rd_n     = sd_rd;
        wr_n     = sd_wr;
        do_load  = 1'b0;
        load_idx = sel;
        case (state)
            WAITACK: begin
                if (!sd_ack) state_n = IDLE;
            end
            IDLE: begin
                if (pick_valid) begin
                    sel_n    = pick_idx;
                    load_idx = pick_idx;
                    do_load  = 1'b1;
                    state_n  = XFER;
                end
            end
            XFER: begin
                if (sd_ack) begin
                    rd_n = 1'b0;
                    wr_n = 1'b0;
                end
                if (old_ack && !sd_ack) begin
                    if (req_lock[sel]) begin
                        state_n = HOLD;
                        timer_n = '0;
                    end else begin
                        state_n  = IDLE;
                        rr_ptr_n = next_ptr;
                    end
                end
            end
            HOLD: begin
                if (req_rd[sel] || req_wr[sel]) begin
                    do_load = 1'b1;
                    state_n = XFER;
                    timer_n = '0;
                end else if (!req_lock[sel] || (timer == TMAX)) begin
                    state_n  = IDLE;
                    rr_ptr_n = next_ptr;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: state_n = WAITACK;
        endcase
        // A write request overrides a simultaneous read from the same unit.
        if (do_load) begin
            lba_n = lba_a[load_idx];
            wr_n  = req_wr[load_idx];
            rd_n  = req_rd[load_idx] & ~req_wr[load_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= WAITACK;
            sel     <= '0;
            rr_ptr  <= '0;
            timer   <= '0;
            sd_lba  <= '0;
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
            old_ack <= 1'b0;
        end else begin
            state   <= state_n;
            sel     <= sel_n;
            rr_ptr  <= rr_ptr_n;
            timer   <= timer_n;
            sd_lba  <= lba_n;
            sd_rd   <= rd_n;
            sd_wr   <= wr_n;
            old_ack <= sd_ack;
        end
    end

endmodule

// File: tb/tb_floppy_sd_arbiter.sv
// tb/tb_floppy_sd_arbiter.sv - table-driven and sequence checks for floppy_sd_arbiter
module tb_floppy_sd_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_rd, req_wr, req_lock, req_ack;
    logic [127:0] req_lba;
    logic [31:0]  req_buff_din;
    logic [31:0]  sd_lba;
    logic         sd_rd, sd_wr, sd_ack, grant_valid;
    logic [7:0]   sd_buff_din;
    logic [1:0]   grant_id;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  rd, wr;
        logic        ack;
        logic        e_rd, e_wr, e_gv;
        logic [1:0]  e_gid;
        logic [3:0]  e_rack;
        logic [31:0] e_lba;
        logic [7:0]  e_din;
    } vec_t;

    vec_t tbl[$];

    floppy_sd_arbiter #(.N(4), .TIMEOUT(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .req_lba      (req_lba),
        .req_lock     (req_lock),
        .req_buff_din (req_buff_din),
        .req_ack      (req_ack),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_din  (sd_buff_din),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic [3:0] rd, input logic [3:0] wr,
                                input logic ack, input logic e_rd, input logic e_wr,
                                input logic e_gv, input logic [1:0] e_gid, input logic [3:0] e_rack,
                                input logic [31:0] e_lba, input logic [7:0] e_din);
        vec_t v;
        v.rst = rst; v.rd = rd; v.wr = wr; v.ack = ack;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_gv = e_gv; v.e_gid = e_gid;
        v.e_rack = e_rack; v.e_lba = e_lba; v.e_din = e_din;
        return v;
    endfunction

    function automatic logic [31:0] lba_of(input int id);
        case (id)
            0: return 32'h0000_0A00;
            1: return 32'h0000_0B01;
            2: return 32'h0000_0640;
            default: return 32'h0000_0F03;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sector(input int id);
        int n;
        n = 0;
        while (!(sd_rd || sd_wr) && n < 20) begin
            step();
            n++;
        end
        chk($sformatf("strobe seen id%0d", id), 32'(sd_rd | sd_wr), 32'd1);
        chk($sformatf("grant id%0d", id), 32'(grant_id), 32'(id));
        chk($sformatf("lba id%0d", id), sd_lba, lba_of(id));
        sd_ack = 1'b1;
        step();
        chk($sformatf("strobe drop id%0d", id), 32'({sd_rd, sd_wr}), 32'd0);
        chk($sformatf("req_ack route id%0d", id), 32'(req_ack), 32'(1 << id));
        req_rd[id] = 1'b0;
        req_wr[id] = 1'b0;
        step();
        sd_ack = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        req_rd       = '0;
        req_wr       = '0;
        req_lock     = '0;
        sd_ack       = 1'b0;
        req_lba      = {32'h0000_0F03, 32'h0000_0640, 32'h0000_0B01, 32'h0000_0A00};
        req_buff_din = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

        //                 rst rd    wr    ack rd wr gv gid   rack  lba           din
        tbl.push_back(mk(1, 4'h0, 4'h0, 0, 0, 0, 0, 2'd0, 4'h0, 32'h0,     8'h00));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 0, 0, 2'd0, 4'h0, 32'h0,     8'h00));
        tbl.push_back(mk(0, 4'h4, 4'h0, 0, 1, 0, 1, 2'd2, 4'h0, 32'h640,   8'hA2));
        tbl.push_back(mk(0, 4'h4, 4'h0, 1, 0, 0, 1, 2'd2, 4'h4, 32'h640,   8'hA2));
        tbl.push_back(mk(0, 4'h0, 4'h0, 1, 0, 0, 1, 2'd2, 4'h4, 32'h640,   8'hA2));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 0, 0, 2'd2, 4'h0, 32'h640,   8'h00));
        tbl.push_back(mk(0, 4'h0, 4'h8, 0, 0, 1, 1, 2'd3, 4'h0, 32'hF03,   8'hA3));
        tbl.push_back(mk(0, 4'h0, 4'h8, 1, 0, 0, 1, 2'd3, 4'h8, 32'hF03,   8'hA3));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 0, 0, 2'd3, 4'h0, 32'hF03,   8'h00));
        tbl.push_back(mk(0, 4'hA, 4'h0, 0, 1, 0, 1, 2'd1, 4'h0, 32'hB01,   8'hA1));
        tbl.push_back(mk(0, 4'hA, 4'h0, 1, 0, 0, 1, 2'd1, 4'h2, 32'hB01,   8'hA1));
        tbl.push_back(mk(0, 4'h8, 4'h0, 1, 0, 0, 1, 2'd1, 4'h2, 32'hB01,   8'hA1));
        tbl.push_back(mk(0, 4'h8, 4'h0, 0, 0, 0, 0, 2'd1, 4'h0, 32'hB01,   8'h00));
        tbl.push_back(mk(0, 4'h8, 4'h0, 0, 1, 0, 1, 2'd3, 4'h0, 32'hF03,   8'hA3));
        tbl.push_back(mk(0, 4'h8, 4'h0, 1, 0, 0, 1, 2'd3, 4'h8, 32'hF03,   8'hA3));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 0, 0, 2'd3, 4'h0, 32'hF03,   8'h00));
        tbl.push_back(mk(0, 4'h2, 4'h2, 0, 0, 1, 1, 2'd1, 4'h0, 32'hB01,   8'hA1));
        tbl.push_back(mk(0, 4'h2, 4'h2, 1, 0, 0, 1, 2'd1, 4'h2, 32'hB01,   8'hA1));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 0, 0, 2'd1, 4'h0, 32'hB01,   8'h00));
        tbl.push_back(mk(0, 4'h0, 4'h0, 1, 0, 0, 0, 2'd1, 4'h0, 32'hB01,   8'h00));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 0, 0, 2'd1, 4'h0, 32'hB01,   8'h00));

        for (int i = 0; i < tbl.size(); i++) begin
            reset  = tbl[i].rst;
            req_rd = tbl[i].rd;
            req_wr = tbl[i].wr;
            sd_ack = tbl[i].ack;
            step();
            chk($sformatf("v%0d sd_rd", i), 32'(sd_rd), 32'(tbl[i].e_rd));
            chk($sformatf("v%0d sd_wr", i), 32'(sd_wr), 32'(tbl[i].e_wr));
            chk($sformatf("v%0d grant_valid", i), 32'(grant_valid), 32'(tbl[i].e_gv));
            chk($sformatf("v%0d grant_id", i), 32'(grant_id), 32'(tbl[i].e_gid));
            chk($sformatf("v%0d req_ack", i), 32'(req_ack), 32'(tbl[i].e_rack));
            chk($sformatf("v%0d sd_lba", i), sd_lba, tbl[i].e_lba);
            chk($sformatf("v%0d sd_buff_din", i), 32'(sd_buff_din), 32'(tbl[i].e_din));
        end

        // Locked 20-sector burst on requester 0 while requester 1 keeps asking.
        req_lock = 4'b0001;
        req_rd   = 4'b0011;
        for (int s = 0; s < 20; s++) begin
            sector(0);
            chk($sformatf("burst hold s%0d", s), 32'(grant_valid), 32'd1);
            if (s < 19) req_rd[0] = 1'b1;
        end
        req_lock[0] = 1'b0;
        step();
        chk("lock drop releases", 32'(grant_valid), 32'd0);
        sector(1);

        // Idle lock on requester 2 is forcibly released after 16 HOLD cycles.
        req_lock = 4'b0100;
        req_rd   = 4'b0100;
        sector(2);
        req_rd[3] = 1'b1;
        for (int c = 0; c < 15; c++) step();
        chk("hold before timeout", 32'(grant_valid), 32'd1);
        chk("hold ignores others", 32'(grant_id), 32'd2);
        step();
        chk("forced release", 32'(grant_valid), 32'd0);
        sector(3);
        req_lock = '0;

        // Reset in the middle of a transfer with the host ack still high.
        req_rd[1] = 1'b1;
        step();
        chk("pre-reset strobe", 32'(sd_rd), 32'd1);
        sd_ack = 1'b1;
        step();
        chk("pre-reset ack", 32'(req_ack), 32'h2);
        reset = 1'b1;
        step();
        chk("reset sd_rd/sd_wr", 32'({sd_rd, sd_wr}), 32'd0);
        chk("reset sd_lba", sd_lba, 32'd0);
        chk("reset grant", 32'({grant_valid, grant_id}), 32'd0);
        chk("reset req_ack", 32'(req_ack), 32'd0);
        chk("reset buff_din", 32'(sd_buff_din), 32'd0);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("waitack gv c%0d", c), 32'(grant_valid), 32'd0);
            chk($sformatf("waitack strobe c%0d", c), 32'(sd_rd), 32'd0);
            chk($sformatf("waitack req_ack c%0d", c), 32'(req_ack), 32'd0);
        end
        sd_ack = 1'b0;
        step();
        chk("ack drop to idle", 32'(grant_valid), 32'd0);
        step();
        chk("post-reset strobe", 32'(sd_rd), 32'd1);
        chk("post-reset grant", 32'(grant_id), 32'd1);
        chk("post-reset lba", sd_lba, 32'h0000_0B01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
